// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> EXEC/MEM -> WB with registered field decode.
// Optional memory-wait timeout with sticky error, enabled by defining CU_TIMEOUT_EN.
module multicycle_control_unit #(
    parameter int INST_W  = 20,
    parameter int REG_AW  = 4,
    parameter int MEM_AW  = 10,
    parameter int IMM_W   = 8,
    parameter int JIMM_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inst_valid,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_inst_ready,
    input  logic              i_mem_ack,
    input  logic              i_cond_true,
    output logic [3:0]        o_alu_op,
    output logic [REG_AW-1:0] o_reg_no_dest,
    output logic [REG_AW-1:0] o_reg_no_src1,
    output logic [REG_AW-1:0] o_reg_no_src2,
    output logic [IMM_W-1:0]  o_imm,
    output logic [JIMM_W-1:0] o_jump_imm,
    output logic [MEM_AW-1:0] o_mem_address,
    output logic              o_mem_load_enable,
    output logic              o_mem_store_enable,
    output logic              o_reg_load_enable,
    output logic              o_jump_imm_sel,
    output logic              o_pc_load,
    output logic              o_mem_error
);

    localparam int FW = INST_W - 4;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_LOAD, C_ALU_RR, C_ALU_RI, C_BRANCH, C_JUMP, C_STORE} cls_t;

    function automatic cls_t f_class(input logic [3:0] op);
        case (op)
            4'b0000:                            f_class = C_LOAD;
            4'b0001, 4'b0010, 4'b0011, 4'b0100: f_class = C_ALU_RR;
            4'b0101, 4'b0110, 4'b0111, 4'b1000: f_class = C_ALU_RI;
            4'b1101:                            f_class = C_JUMP;
            4'b1111:                            f_class = C_STORE;
            default:                            f_class = C_BRANCH;
        endcase
    endfunction

    state_t            r_state, w_next;
    logic [INST_W-1:0] r_ir, w_ir_next;
    logic              w_accept;
    cls_t              w_cls, w_dcls;
    logic [FW-1:0]     w_f;

    logic [3:0]        r_alu_op, w_d_op;
    logic [REG_AW-1:0] r_dest, r_src1, r_src2, w_d_dest, w_d_src1, w_d_src2;
    logic [IMM_W-1:0]  r_imm, w_d_imm;
    logic [JIMM_W-1:0] r_jimm, w_d_jimm;
    logic [MEM_AW-1:0] r_maddr, w_d_maddr;

    assign w_accept  = (r_state == S_FETCH) && i_inst_valid;
    assign w_ir_next = w_accept ? i_inst : r_ir;
    assign w_cls     = f_class(r_ir[INST_W-1 -: 4]);

`ifdef CU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_tmo_cnt;
    logic          r_mem_error;
    logic          w_tmo;

    assign w_tmo = (r_state == S_MEM) && !i_mem_ack && (r_tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt   <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == S_MEM && w_next == S_MEM) ? r_tmo_cnt + 1'b1 : '0;
            if (w_tmo)
                r_mem_error <= 1'b1;
        end
    end

    assign o_mem_error = r_mem_error;
`else
    assign o_mem_error = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next             = r_state;
        o_inst_ready       = 1'b0;
        o_mem_load_enable  = 1'b0;
        o_mem_store_enable = 1'b0;
        o_reg_load_enable  = 1'b0;
        o_jump_imm_sel     = 1'b0;
        o_pc_load          = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_inst_ready = !i_rst;
                if (i_inst_valid)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_cls == C_LOAD || w_cls == C_STORE) ? S_MEM : S_EXEC;
            end
            S_EXEC: begin
                case (w_cls)
                    C_ALU_RR, C_ALU_RI: w_next = S_WB;
                    C_BRANCH: begin
                        o_pc_load      = 1'b1;
                        o_jump_imm_sel = i_cond_true;
                        w_next         = S_FETCH;
                    end
                    C_JUMP: begin
                        o_pc_load      = 1'b1;
                        o_jump_imm_sel = 1'b1;
                        w_next         = S_FETCH;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                o_mem_load_enable  = (w_cls == C_LOAD);
                o_mem_store_enable = (w_cls == C_STORE);
                if (i_mem_ack) begin
                    if (w_cls == C_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        o_pc_load = 1'b1;
                        w_next    = S_FETCH;
                    end
                end
`ifdef CU_TIMEOUT_EN
                else if (w_tmo) begin
                    o_pc_load = 1'b1;
                    w_next    = S_FETCH;
                end
`endif
            end
            S_WB: begin
                o_reg_load_enable = 1'b1;
                o_pc_load         = 1'b1;
                w_next            = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Decode from the IR's next value so fields are already registered during DECODE.
    assign w_f    = w_ir_next[FW-1:0];
    assign w_dcls = f_class(w_ir_next[INST_W-1 -: 4]);

    always_comb begin
        w_d_op    = w_ir_next[INST_W-1 -: 4];
        w_d_dest  = '0;
        w_d_src1  = '0;
        w_d_src2  = '0;
        w_d_imm   = '0;
        w_d_jimm  = '0;
        w_d_maddr = '0;
        case (w_dcls)
            C_LOAD: begin
                w_d_dest  = w_f[FW-1 -: REG_AW];
                w_d_maddr = w_f[MEM_AW-1:0];
            end
            C_ALU_RR: begin
                w_d_dest = w_f[FW-1 -: REG_AW];
                w_d_src1 = w_f[FW-1-REG_AW -: REG_AW];
                w_d_src2 = w_f[FW-1-2*REG_AW -: REG_AW];
            end
            C_ALU_RI: begin
                w_d_dest = w_f[FW-1 -: REG_AW];
                w_d_src1 = w_f[FW-1-REG_AW -: REG_AW];
                w_d_imm  = w_f[IMM_W-1:0];
            end
            C_BRANCH: begin
                w_d_src1 = w_f[FW-1 -: REG_AW];
                w_d_src2 = w_f[FW-1-REG_AW -: REG_AW];
                w_d_jimm = JIMM_W'(signed'(w_f[IMM_W-1:0]));
            end
            C_JUMP: begin
                w_d_jimm = w_f[JIMM_W-1:0];
            end
            C_STORE: begin
                w_d_src1  = w_f[FW-1 -: REG_AW];
                w_d_maddr = w_f[MEM_AW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ir     <= '0;
            r_alu_op <= '0;
            r_dest   <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_imm    <= '0;
            r_jimm   <= '0;
            r_maddr  <= '0;
        end else begin
            r_ir <= w_ir_next;
            if (w_next == S_FETCH) begin
                r_alu_op <= '0;
                r_dest   <= '0;
                r_src1   <= '0;
                r_src2   <= '0;
                r_imm    <= '0;
                r_jimm   <= '0;
                r_maddr  <= '0;
            end else begin
                r_alu_op <= w_d_op;
                r_dest   <= w_d_dest;
                r_src1   <= w_d_src1;
                r_src2   <= w_d_src2;
                r_imm    <= w_d_imm;
                r_jimm   <= w_d_jimm;
                r_maddr  <= w_d_maddr;
            end
        end
    end

    assign o_alu_op      = r_alu_op;
    assign o_reg_no_dest = r_dest;
    assign o_reg_no_src1 = r_src1;
    assign o_reg_no_src2 = r_src2;
    assign o_imm         = r_imm;
    assign o_jump_imm    = r_jimm;
    assign o_mem_address = r_maddr;

endmodule
